fisc_exc_sequencer: RTL
=======================

Name: fisc_exc_sequencer

Overview:
- Multi-cycle initiator that drives the FISC register-file access port (rd_reg/wr_reg/wr_fromreg/wr_fromimm/din_reg, dout_reg return).
- Performs exception/IRQ entry and ERET as a fixed sequence of register-file transactions:
  - Entry saves CPSR into SPSR and PC into ELR, writes ESR, loads PC from EVP or IVP, then writes CPSR.
  - ERET restores PC and CPSR.
- Sits in fisc_core between the control unit and the register file.
- Owns the register-file port only while busy=1.

Parameters:
- XLEN, `FISC_INTEGER_SZ (64), data width of din_reg/dout_reg.
- SPSR_BASE, 36, register index of spsr[0]; spsr for mode m is at SPSR_BASE+m-1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- exc_valid  in  1  exception/IRQ entry request
- exc_is_irq  in  1  1 = vector from IVP (42); 0 = vector from EVP (43)
- exc_mode  in  3  target mode, legal 1..6
- exc_syndrome  in  XLEN  value written to ESR
- eret_valid  in  1  exception-return request
- req_ready  out  1  1 only in IDLE; request accepted on valid&&req_ready
- busy  out  1  sequencer owns register port
- done  out  1  one-cycle pulse, sequence complete
- err  out  1  one-cycle pulse, illegal mode, no register writes performed
- rd_reg  out  6  register-file read index
- wr_reg  out  6  register-file write index
- wr_fromreg  out  1  reg[wr_reg] <= reg[rd_reg]
- wr_fromimm  out  1  reg[wr_reg] <= din_reg
- din_reg  out  XLEN  immediate write data
- reg_dout  in  XLEN  register-file dout_reg (combinational, valid when both write flags are 0)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0, except req_ready=1 once out of reset.
  - Captured CPSR, mode and syndrome registers are cleared.
- All outputs are registered from state. wr_fromreg and wr_fromimm are never 1 together.
- IDLE: register-port outputs are all 0.
  - exc_valid has priority over eret_valid when both are asserted.
  - Request inputs are latched at acceptance.
- Entry sequence, one state per cycle, cycle count from acceptance edge:
  - E1 RD_CPSR: rd=35, flags 0. cpsr_q <= reg_dout[11:0]. Checks exc_mode; if 0 or 7, go to FAULT.
  - E2 SAVE_SPSR: rd=35, wr=SPSR_BASE+mode-1, wr_fromreg=1.
  - E3 SAVE_ELR: rd=32, wr=34, wr_fromreg=1.
  - E4 WR_ESR: wr=33, din=syndrome, wr_fromimm=1.
  - E5 LD_PC: rd=42 if irq else 43, wr=32, wr_fromreg=1.
  - E6 WR_CPSR: wr=35, wr_fromimm=1, din={52'b0, cpsr_q[11:4], 1'b1, mode[2:0]}. Bit 3 = IRQ mask.
  - E7 DONE: done=1, then IDLE.
  - busy=1 from E1 through E7 inclusive.
- ERET sequence:
  - R1 RD_CPSR: captures CPSR. If cpsr_q[2:0] is 0 or 7, go to FAULT.
  - R2 RET_PC: rd=34, wr=32, wr_fromreg=1.
  - R3 RET_CPSR: rd=SPSR_BASE+cur-1, wr=35, wr_fromreg=1.
  - R4 DONE.
- FAULT: err=1 and done=0 for one cycle, then IDLE. No write flags are asserted in any cycle of a faulted request.
- Requests arriving while busy are ignored; requesters hold valid until accepted.
- rst_n asserted mid-sequence aborts immediately. Partially written registers are not rolled back. No done pulse is produced.
- Back-to-back operation: a request seen in IDLE the cycle after DONE is accepted. Minimum spacing is 8 cycles for entry and 5 for ERET.

Optional Feature:
- FISC_EXC_PFLA_EN
  - Defined: adds input exc_fault_addr[XLEN-1:0] and input exc_is_pf. When exc_is_pf is latched 1, state E4b WR_PFLA (wr=45, din=fault_addr, wr_fromimm=1) is inserted after E4, making entry 8 cycles.
  - Undefined: ports absent, PFLA never written, entry is 7 cycles.

Decomposition:
- Package fisc_exc_pkg holds:
  - Register index constants: PC=32, ESR=33, ELR=34, CPSR=35, SPSR_BASE=36, IVP=42, EVP=43, PFLA=45.
  - State enum typedef.
  - CPSR field localparams: MODE=[2:0], IMASK=[3].
- No sub-module; a single FSM with a registered output decode.

Test Plan:
- Sync entry: CPSR=0x0A0, PC=0x1000, EVP=0x8000, exc_mode=2, syndrome=0xDEAD -> after done: spsr[1]=0x0A0, ELR=0x1000, ESR=0xDEAD, PC=0x8000, CPSR=0x0AA; done exactly 7 cycles after acceptance.
- IRQ entry with IVP=0x9000, mode=1 -> PC=0x9000, spsr[0]=old CPSR, CPSR[3]=1.
- ERET with CPSR=0x0AA, ELR=0x1004, spsr[1]=0x0A0 -> PC=0x1004, CPSR=0x0A0; done 4 cycles after acceptance.
- Illegal: exc_mode=0, and separately ERET with CPSR mode 0 -> err pulse, zero write-flag cycles, register file unchanged.
- exc_valid and eret_valid together, then rst_n low at E3 -> entry chosen; after reset all outputs 0, no done, next request accepted normally.
- With FISC_EXC_PFLA_EN, exc_is_pf=1, fault_addr=0xBEEF000 -> PFLA=0xBEEF000; done at cycle 8.

Source files
------------

// File: rtl/fisc_exc_pkg.sv
// Shared register indices, CPSR field positions and FSM state encoding for the
// FISC exception sequencer.
`ifndef FISC_INTEGER_SZ
`define FISC_INTEGER_SZ 64
`endif

package fisc_exc_pkg;

  localparam int XLEN_DEF = `FISC_INTEGER_SZ;

  localparam logic [5:0] REG_PC        = 6'd32;
  localparam logic [5:0] REG_ESR       = 6'd33;
  localparam logic [5:0] REG_ELR       = 6'd34;
  localparam logic [5:0] REG_CPSR      = 6'd35;
  localparam logic [5:0] REG_SPSR_BASE = 6'd36;
  localparam logic [5:0] REG_IVP       = 6'd42;
  localparam logic [5:0] REG_EVP       = 6'd43;
  localparam logic [5:0] REG_PFLA      = 6'd45;

  localparam int CPSR_MODE_MSB = 2;
  localparam int CPSR_MODE_LSB = 0;
  localparam int CPSR_IMASK    = 3;
  localparam int CPSR_W        = 12;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_E1_RD_CPSR   = 4'd1,
    ST_E2_SAVE_SPSR = 4'd2,
    ST_E3_SAVE_ELR  = 4'd3,
    ST_E4_WR_ESR    = 4'd4,
    ST_E4B_WR_PFLA  = 4'd5,
    ST_E5_LD_PC     = 4'd6,
    ST_E6_WR_CPSR   = 4'd7,
    ST_E7_DONE      = 4'd8,
    ST_R1_RD_CPSR   = 4'd9,
    ST_R2_RET_PC    = 4'd10,
    ST_R3_RET_CPSR  = 4'd11,
    ST_R4_DONE      = 4'd12,
    ST_FAULT        = 4'd13
  } exc_state_e;

  // Modes 0 and 7 have no banked SPSR.
  function automatic logic mode_illegal(input logic [2:0] m);
    return (m == 3'd0) || (m == 3'd7);
  endfunction

endpackage

// File: rtl/fisc_exc_sequencer.sv
// Exception/IRQ entry and ERET sequencer driving the FISC register-file port.
// Optional macro FISC_EXC_PFLA_EN adds a page-fault address write (PFLA) to entry.
module fisc_exc_sequencer
  import fisc_exc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int SPSR_BASE = 36
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid,
  input  logic            exc_is_irq,
  input  logic [2:0]      exc_mode,
  input  logic [XLEN-1:0] exc_syndrome,
`ifdef FISC_EXC_PFLA_EN
  input  logic [XLEN-1:0] exc_fault_addr,
  input  logic            exc_is_pf,
`endif
  input  logic            eret_valid,
  output logic            req_ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [5:0]      rd_reg,
  output logic [5:0]      wr_reg,
  output logic            wr_fromreg,
  output logic            wr_fromimm,
  output logic [XLEN-1:0] din_reg,
  input  logic [XLEN-1:0] reg_dout
);

  exc_state_e        state_r, state_nxt_s;
  logic [2:0]        mode_r;
  logic              irq_r;
  logic [XLEN-1:0]   syn_r;
  logic [CPSR_W-1:0] cpsr_r;
  logic              accept_exc_s, accept_eret_s;
  logic              pf_s;
  logic [XLEN-1:0]   pfla_s;
  logic [5:0]        spsr_save_idx_s, spsr_ret_idx_s;
  logic              ready_s, busy_s, done_s, err_s, fromreg_s, fromimm_s;
  logic [5:0]        rd_s, wr_s;
  logic [XLEN-1:0]   din_s;
  logic              unused_dout_s;

`ifdef FISC_EXC_PFLA_EN
  logic            pf_r;
  logic [XLEN-1:0] pfla_r;
  assign pf_s   = pf_r;
  assign pfla_s = pfla_r;
`else
  assign pf_s   = 1'b0;
  assign pfla_s = '0;
`endif

  assign unused_dout_s   = ^reg_dout[XLEN-1:CPSR_W];
  assign spsr_save_idx_s = 6'(SPSR_BASE) + {3'b000, mode_r} - 6'd1;
  assign spsr_ret_idx_s  = 6'(SPSR_BASE) + {3'b000, cpsr_r[CPSR_MODE_MSB:CPSR_MODE_LSB]} - 6'd1;

  // Next-state selection; exc_valid wins over eret_valid in IDLE.
  always_comb begin
    state_nxt_s   = state_r;
    accept_exc_s  = 1'b0;
    accept_eret_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_ready && exc_valid) begin
          state_nxt_s  = ST_E1_RD_CPSR;
          accept_exc_s = 1'b1;
        end else if (req_ready && eret_valid) begin
          state_nxt_s   = ST_R1_RD_CPSR;
          accept_eret_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_E1_RD_CPSR:   state_nxt_s = mode_illegal(mode_r) ? ST_FAULT : ST_E2_SAVE_SPSR;
      ST_E2_SAVE_SPSR: state_nxt_s = ST_E3_SAVE_ELR;
      ST_E3_SAVE_ELR:  state_nxt_s = ST_E4_WR_ESR;
      ST_E4_WR_ESR:    state_nxt_s = pf_s ? ST_E4B_WR_PFLA : ST_E5_LD_PC;
      ST_E4B_WR_PFLA:  state_nxt_s = ST_E5_LD_PC;
      ST_E5_LD_PC:     state_nxt_s = ST_E6_WR_CPSR;
      ST_E6_WR_CPSR:   state_nxt_s = ST_E7_DONE;
      ST_E7_DONE:      state_nxt_s = ST_IDLE;
      ST_R1_RD_CPSR:   state_nxt_s = mode_illegal(reg_dout[CPSR_MODE_MSB:CPSR_MODE_LSB]) ?
                                     ST_FAULT : ST_R2_RET_PC;
      ST_R2_RET_PC:    state_nxt_s = ST_R3_RET_CPSR;
      ST_R3_RET_CPSR:  state_nxt_s = ST_R4_DONE;
      ST_R4_DONE:      state_nxt_s = ST_IDLE;
      ST_FAULT:        state_nxt_s = ST_IDLE;
      default:         state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode of the state being entered, so the port changes with the state.
  always_comb begin
    ready_s   = 1'b0;
    busy_s    = 1'b1;
    done_s    = 1'b0;
    err_s     = 1'b0;
    rd_s      = 6'd0;
    wr_s      = 6'd0;
    fromreg_s = 1'b0;
    fromimm_s = 1'b0;
    din_s     = '0;
    case (state_nxt_s)
      ST_IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      ST_E1_RD_CPSR, ST_R1_RD_CPSR: rd_s = REG_CPSR;
      ST_E2_SAVE_SPSR: begin
        rd_s = REG_CPSR; wr_s = spsr_save_idx_s; fromreg_s = 1'b1;
      end
      ST_E3_SAVE_ELR: begin
        rd_s = REG_PC; wr_s = REG_ELR; fromreg_s = 1'b1;
      end
      ST_E4_WR_ESR: begin
        wr_s = REG_ESR; din_s = syn_r; fromimm_s = 1'b1;
      end
      ST_E4B_WR_PFLA: begin
        wr_s = REG_PFLA; din_s = pfla_s; fromimm_s = 1'b1;
      end
      ST_E5_LD_PC: begin
        rd_s = irq_r ? REG_IVP : REG_EVP; wr_s = REG_PC; fromreg_s = 1'b1;
      end
      ST_E6_WR_CPSR: begin
        wr_s = REG_CPSR; fromimm_s = 1'b1;
        din_s = {{(XLEN-CPSR_W){1'b0}}, cpsr_r[CPSR_W-1:CPSR_IMASK+1], 1'b1, mode_r};
      end
      ST_R2_RET_PC: begin
        rd_s = REG_ELR; wr_s = REG_PC; fromreg_s = 1'b1;
      end
      ST_R3_RET_CPSR: begin
        rd_s = spsr_ret_idx_s; wr_s = REG_CPSR; fromreg_s = 1'b1;
      end
      ST_E7_DONE, ST_R4_DONE: done_s = 1'b1;
      ST_FAULT:               err_s  = 1'b1;
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, request latches, captured CPSR and registered port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mode_r     <= 3'd0;
      irq_r      <= 1'b0;
      syn_r      <= '0;
      cpsr_r     <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rd_reg     <= 6'd0;
      wr_reg     <= 6'd0;
      wr_fromreg <= 1'b0;
      wr_fromimm <= 1'b0;
      din_reg    <= '0;
`ifdef FISC_EXC_PFLA_EN
      pf_r       <= 1'b0;
      pfla_r     <= '0;
`endif
    end else begin
      state_r <= state_nxt_s;
      if (accept_exc_s) begin
        mode_r <= exc_mode;
        irq_r  <= exc_is_irq;
        syn_r  <= exc_syndrome;
`ifdef FISC_EXC_PFLA_EN
        pf_r   <= exc_is_pf;
        pfla_r <= exc_fault_addr;
`endif
      end
      if (state_r == ST_E1_RD_CPSR || state_r == ST_R1_RD_CPSR) begin
        cpsr_r <= reg_dout[CPSR_W-1:0];
      end
      req_ready  <= ready_s;
      busy       <= busy_s;
      done       <= done_s;
      err        <= err_s;
      rd_reg     <= rd_s;
      wr_reg     <= wr_s;
      wr_fromreg <= fromreg_s;
      wr_fromimm <= fromimm_s;
      din_reg    <= din_s;
    end
  end

endmodule
